// File: rtl/uart_tx_configuravel_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_tx_configuravel_if                                                 |
// | Write/status bundle between the frame formatter and the UART TX core.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface uart_tx_configuravel_if #(
  parameter int DATA_BITS = 8
);
  logic                 haDadosParaTransmitir;
  logic [DATA_BITS-1:0] byteASerTransmitido;
  logic                 filaCheia;
  logic                 filaVazia;
  logic                 erroEstouro;
  logic                 indicaTransmissao;
  logic                 bitSerialAtual;
  logic                 bitsEstaoEnviados;

  modport master (
    output haDadosParaTransmitir,
    output byteASerTransmitido,
    input  filaCheia,
    input  filaVazia,
    input  erroEstouro,
    input  indicaTransmissao,
    input  bitSerialAtual,
    input  bitsEstaoEnviados
  );

  modport slave (
    input  haDadosParaTransmitir,
    input  byteASerTransmitido,
    output filaCheia,
    output filaVazia,
    output erroEstouro,
    output indicaTransmissao,
    output bitSerialAtual,
    output bitsEstaoEnviados
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_configuravel.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_tx_configuravel                                                    |
// | FIFO-fed UART transmitter: 5..9 data bits, optional parity, 1/2 stops.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module uart_tx_configuravel #(
  parameter int CLOCKS_POR_BIT = 5209,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                    clock,
  input  logic                    resetN,
  uart_tx_configuravel_if.slave   tx
);

  localparam int BAUD_W = (CLOCKS_POR_BIT > 1) ? $clog2(CLOCKS_POR_BIT) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLOCKS_POR_BIT - 1);
  localparam logic [BAUD_W-1:0] C_BAUD_PRE  = BAUD_W'(CLOCKS_POR_BIT - 2);
  localparam logic [IDX_W-1:0]  C_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  C_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  C_FULL      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 cheia_q, vazia_q, erro_q;

  // Transmit engine
  estado_t              estado_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 line_q, ind_q, pulse_q;

  logic                 push_w, pop_w, baud_last_w, frame_end_w;
  logic [DATA_BITS-1:0] head_w;

  assign head_w      = mem_q[rd_ptr_q];
  assign baud_last_w = (baud_q == C_BAUD_LAST);
  assign frame_end_w = (estado_q == PARADA) && baud_last_w && (idx_q == C_STOP_LAST);
  assign push_w      = tx.haDadosParaTransmitir && !cheia_q;
  // Pops happen from idle, or at the last stop cycle so frames run back-to-back
  assign pop_w       = !vazia_q && ((estado_q == OCIOSO) || frame_end_w);

  always_comb begin
    count_d = count_q;
    if (push_w && !pop_w) begin
      count_d = count_q + 1'b1;
    end else if (!push_w && pop_w) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= tx.byteASerTransmitido;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cheia_q  <= 1'b0;
      vazia_q  <= 1'b1;
      erro_q   <= 1'b0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      cheia_q <= (count_d == C_FULL);
      vazia_q <= (count_d == '0);
      if (tx.haDadosParaTransmitir && cheia_q) erro_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      estado_q <= OCIOSO;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
      ind_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (pop_w) begin
            shift_q  <= head_w;
            parity_q <= (^head_w) ^ (PARITY == 2);
            baud_q   <= '0;
            idx_q    <= '0;
            estado_q <= INICIO;
            line_q   <= 1'b0;
            ind_q    <= 1'b1;
          end else begin
            line_q <= 1'b1;
            ind_q  <= 1'b0;
          end
        end
        INICIO: begin
          if (baud_last_w) begin
            baud_q   <= '0;
            estado_q <= DADOS;
            line_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DADOS: begin
          if (baud_last_w) begin
            baud_q <= '0;
            if (idx_q == C_DATA_LAST) begin
              idx_q <= '0;
              if (PARITY != 0) begin
                estado_q <= PARIDADE;
                line_q   <= parity_q;
              end else begin
                estado_q <= PARADA;
                line_q   <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_q >> 1;
              line_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        PARIDADE: begin
          if (baud_last_w) begin
            baud_q   <= '0;
            idx_q    <= '0;
            estado_q <= PARADA;
            line_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        PARADA: begin
          // Raise the pulse one edge early so it occupies the final stop cycle
          if ((baud_q == C_BAUD_PRE) && (idx_q == C_STOP_LAST)) begin
            pulse_q <= 1'b1;
          end
          if (frame_end_w) begin
            baud_q <= '0;
            idx_q  <= '0;
            if (pop_w) begin
              shift_q  <= head_w;
              parity_q <= (^head_w) ^ (PARITY == 2);
              estado_q <= INICIO;
              line_q   <= 1'b0;
            end else begin
              estado_q <= OCIOSO;
              line_q   <= 1'b1;
              ind_q    <= 1'b0;
            end
          end else if (baud_last_w) begin
            baud_q <= '0;
            idx_q  <= idx_q + 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          estado_q <= OCIOSO;
          line_q   <= 1'b1;
          ind_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tx.filaCheia         = cheia_q;
  assign tx.filaVazia         = vazia_q;
  assign tx.erroEstouro       = erro_q;
  assign tx.indicaTransmissao = ind_q;
  assign tx.bitSerialAtual    = line_q;
  assign tx.bitsEstaoEnviados = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_configuravel.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_uart_tx_configuravel                                                 |
// | Four transmitter configurations against a waveform-level frame model.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_uart_tx_configuravel;

  localparam int CPB = 4;
  localparam int NI  = 4;
  localparam int DEP = 4;
  // Per-instance configuration, element 0 in the low nibble
  localparam logic [NI-1:0][3:0] DB_A  = {4'd7, 4'd8, 4'd8, 4'd8};
  localparam logic [NI-1:0][3:0] PAR_A = {4'd0, 4'd2, 4'd1, 4'd0};
  localparam logic [NI-1:0][3:0] STP_A = {4'd2, 4'd1, 4'd1, 4'd1};

  logic clock;
  logic resetN;
  logic cmp_en;
  logic [NI-1:0]      wr;
  logic [NI-1:0][8:0] din;
  logic [NI-1:0] d_line, d_ind, d_pulse, d_vaz, d_cheia, d_err;
  logic [NI-1:0] e_line, e_ind, e_pulse, e_vaz, e_cheia, e_err;

  int checks   = 0;
  int failures = 0;
  int pcnt [NI];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int D  = int'(DB_A[g]);
    localparam int PR = int'(PAR_A[g]);
    localparam int SB = int'(STP_A[g]);

    uart_tx_configuravel_if #(.DATA_BITS(D)) ifc ();
    assign ifc.haDadosParaTransmitir = wr[g];
    assign ifc.byteASerTransmitido   = din[g][D-1:0];

    uart_tx_configuravel #(
      .CLOCKS_POR_BIT(CPB),
      .DATA_BITS     (D),
      .PARITY        (PR),
      .STOP_BITS     (SB),
      .FIFO_DEPTH    (DEP)
    ) dut (
      .clock (clock),
      .resetN(resetN),
      .tx    (ifc)
    );

    assign d_line[g]  = ifc.bitSerialAtual;
    assign d_ind[g]   = ifc.indicaTransmissao;
    assign d_pulse[g] = ifc.bitsEstaoEnviados;
    assign d_vaz[g]   = ifc.filaVazia;
    assign d_cheia[g] = ifc.filaCheia;
    assign d_err[g]   = ifc.erroEstouro;

    // Model: queue of pending words plus the remaining line waveform of the frame in flight
    logic [8:0] wq [$];
    logic       st [$];
    logic       m_err, r_line, r_ind, r_pulse, r_vaz, r_cheia, par;
    logic [8:0] w;
    int         n;

    initial begin
      m_err = 1'b0; r_line = 1'b1; r_ind = 1'b0; r_pulse = 1'b0; r_vaz = 1'b1; r_cheia = 1'b0;
      forever begin
        @(posedge clock or negedge resetN);
        if (!resetN) begin
          wq.delete();
          st.delete();
          m_err = 1'b0;
        end else begin
          n = wq.size();
          if (st.size() > 0) void'(st.pop_front());
          if (st.size() == 0 && n > 0) begin
            w   = wq.pop_front();
            par = (PR == 2);
            for (int c = 0; c < CPB; c++) st.push_back(1'b0);
            for (int k = 0; k < D; k++) begin
              par = par ^ w[k];
              for (int c = 0; c < CPB; c++) st.push_back(w[k]);
            end
            if (PR != 0) for (int c = 0; c < CPB; c++) st.push_back(par);
            for (int c = 0; c < SB * CPB; c++) st.push_back(1'b1);
          end
          if (wr[g]) begin
            if (n == DEP) m_err = 1'b1;
            else          wq.push_back(din[g]);
          end
        end
        r_line  = (st.size() > 0) ? st[0] : 1'b1;
        r_ind   = (st.size() > 0);
        r_pulse = (st.size() == 1);
        r_vaz   = (wq.size() == 0);
        r_cheia = (wq.size() == DEP);
      end
    end

    assign e_line[g]  = r_line;
    assign e_ind[g]   = r_ind;
    assign e_pulse[g] = r_pulse;
    assign e_vaz[g]   = r_vaz;
    assign e_cheia[g] = r_cheia;
    assign e_err[g]   = m_err;
  end

  // Cycle compare against the model, plus running completion-pulse counts
  initial begin
    for (int i = 0; i < NI; i++) pcnt[i] = 0;
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("cyc_line[%0d]", i),  32'(d_line[i]),  32'(e_line[i]));
          chk($sformatf("cyc_ind[%0d]", i),   32'(d_ind[i]),   32'(e_ind[i]));
          chk($sformatf("cyc_pulse[%0d]", i), 32'(d_pulse[i]), 32'(e_pulse[i]));
          chk($sformatf("cyc_vazia[%0d]", i), 32'(d_vaz[i]),   32'(e_vaz[i]));
          chk($sformatf("cyc_cheia[%0d]", i), 32'(d_cheia[i]), 32'(e_cheia[i]));
          chk($sformatf("cyc_erro[%0d]", i),  32'(d_err[i]),   32'(e_err[i]));
          if (d_pulse[i] === 1'b1) pcnt[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic frame(input int i, input logic [8:0] wd, input int nb,
                       output logic [15:0] bits, output int pulse_at,
                       output int indc, output int lat);
    bits = '0; pulse_at = -1; indc = 0; lat = 0;
    wr[i] = 1'b1; din[i] = wd;
    tick();
    wr[i] = 1'b0;
    while (d_line[i] !== 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    for (int c = 0; c < nb * CPB; c++) begin
      if (c % CPB == 2) bits[c / CPB] = d_line[i];
      if (d_pulse[i] === 1'b1) pulse_at = c + 1;
      if (d_ind[i] === 1'b1) indc++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int pat, ic, lat, p0, k3, np, indl;
    wr = '0; din = '0; resetN = 1'b0; cmp_en = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_line",  32'(d_line[0]),  32'd1);
    chk("rst_ind",   32'(d_ind[0]),   32'd0);
    chk("rst_vazia", 32'(d_vaz[0]),   32'd1);
    chk("rst_cheia", 32'(d_cheia[0]), 32'd0);
    chk("rst_erro",  32'(d_err[0]),   32'd0);
    chk("rst_pulse", 32'(d_pulse[0]), 32'd0);
    resetN = 1'b1;
    tick();

    // 8N1 0xA5
    frame(0, 9'h0A5, 10, bits, pat, ic, lat);
    chk("8n1_latency", 32'(lat), 32'd1);
    chk("8n1_bits",    32'(bits[9:0]), 32'h34A);
    chk("8n1_pulse_at", 32'(pat), 32'd40);
    chk("8n1_ind_cycles", 32'(ic), 32'd40);

    // Even and odd parity
    frame(1, 9'h0A5, 11, bits, pat, ic, lat);
    chk("even_a5_bits", 32'(bits[10:0]), 32'h54A);
    chk("even_a5_pulse_at", 32'(pat), 32'd44);
    frame(2, 9'h0A5, 11, bits, pat, ic, lat);
    chk("odd_a5_bits", 32'(bits[10:0]), 32'h74A);
    chk("odd_a5_pulse_at", 32'(pat), 32'd44);
    frame(1, 9'h007, 11, bits, pat, ic, lat);
    chk("even_07_parity", 32'(bits[9]), 32'd1);

    // 7 data bits, 2 stop bits
    frame(3, 9'h055, 10, bits, pat, ic, lat);
    chk("7d2s_bits", 32'(bits[9:0]), 32'h3AA);
    chk("7d2s_pulse_at", 32'(pat), 32'd40);
    chk("7d2s_ind_cycles", 32'(ic), 32'd40);
    repeat (2) tick();

    // Back-to-back frames
    p0 = pcnt[0]; k3 = -1; np = 0; indl = 0;
    wr[0] = 1'b1; din[0] = 9'h011; tick();
    din[0] = 9'h022; tick();
    din[0] = 9'h033; tick();
    wr[0] = 1'b0;
    for (int k = 0; k < 125; k++) begin
      if (d_pulse[0] === 1'b1) begin np++; k3 = k; end
      if (d_ind[0] === 1'b1) indl++;
      tick();
    end
    chk("b2b_pulses", 32'(np), 32'd3);
    chk("b2b_third_pulse", 32'(k3), 32'd118);
    chk("b2b_ind_cycles", 32'(indl), 32'd119);
    chk("b2b_pulse_count", 32'(pcnt[0] - p0), 32'd3);
    chk("b2b_vazia", 32'(d_vaz[0]), 32'd1);

    // Overflow with a depth-4 FIFO
    p0 = pcnt[0];
    for (int j = 0; j < 6; j++) begin
      wr[0] = 1'b1; din[0] = 9'(j + 1);
      tick();
      if (j == 4) begin
        chk("ovf_cheia_at_5", 32'(d_cheia[0]), 32'd1);
        chk("ovf_erro_before", 32'(d_err[0]), 32'd0);
      end
    end
    wr[0] = 1'b0;
    chk("ovf_erro", 32'(d_err[0]), 32'd1);
    chk("ovf_cheia_at_6", 32'(d_cheia[0]), 32'd1);
    repeat (5 * 40 + 8) tick();
    chk("ovf_frames", 32'(pcnt[0] - p0), 32'd5);
    chk("ovf_erro_sticky", 32'(d_err[0]), 32'd1);

    // Reset during the data phase with two words queued
    wr[0] = 1'b1; din[0] = 9'h081; tick();
    din[0] = 9'h082; tick();
    din[0] = 9'h083; tick();
    wr[0] = 1'b0;
    repeat (8) tick();
    chk("mid_in_frame", 32'(d_ind[0]), 32'd1);
    p0 = pcnt[0];
    resetN = 1'b0;
    #1;
    chk("mid_rst_line",  32'(d_line[0]),  32'd1);
    chk("mid_rst_vazia", 32'(d_vaz[0]),   32'd1);
    chk("mid_rst_ind",   32'(d_ind[0]),   32'd0);
    chk("mid_rst_erro",  32'(d_err[0]),   32'd0);
    chk("mid_rst_cheia", 32'(d_cheia[0]), 32'd0);
    repeat (2) tick();
    resetN = 1'b1;
    tick();
    frame(0, 9'h0C3, 10, bits, pat, ic, lat);
    chk("post_rst_bits", 32'(bits[9:0]), 32'h386);
    chk("post_rst_pulse_at", 32'(pat), 32'd40);
    chk("post_rst_pulses", 32'(pcnt[0] - p0), 32'd1);
    repeat (3) tick();
    chk("post_rst_idle", 32'(d_ind[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_configuravel.md
Name: uart_tx_configuravel

Overview:
- Parametrised successor to the team's fixed 8N1 UART transmitter.
- Configurable data width, optional even/odd parity, 1 or 2 stop bits.
- Small input FIFO so the sensor/command logic can queue several bytes and frames go out back-to-back.
- Sits between the DHT11 response/command formatter and the FPGA TX pin.

Parameters:
- CLOCKS_POR_BIT, 5209, clock cycles per serial bit (50 MHz / 9600 baud); minimum 2.
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- haDadosParaTransmitir  in  1  write strobe; one word is offered per high cycle.
- byteASerTransmitido  in  DATA_BITS  word to enqueue.
- filaCheia  out  1  FIFO holds FIFO_DEPTH words.
- filaVazia  out  1  FIFO holds 0 words.
- erroEstouro  out  1  sticky flag: a write was offered while full.
- indicaTransmissao  out  1  a frame is on the line.
- bitSerialAtual  out  1  serial TX line; idle high.
- bitsEstaoEnviados  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (resetN=0, asynchronous):
  - Outputs: bitSerialAtual=1, indicaTransmissao=0, bitsEstaoEnviados=0, erroEstouro=0, filaVazia=1, filaCheia=0.
  - FIFO pointers, count, bit counter and baud counter are cleared; state=OCIOSO.
  - A mid-frame reset aborts the frame: no completion pulse, queued words are lost.
  - Release is synchronous to the next rising edge.
- FIFO:
  - Write is accepted when haDadosParaTransmitir=1 and filaCheia=0.
  - Write while filaCheia=1: data is dropped, erroEstouro is set and held until reset. This also applies when a pop happens in the same cycle, because fullness is evaluated on the pre-edge count.
  - Simultaneous accepted write and pop: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - filaCheia and filaVazia are registered and reflect the count after each edge.
- Counters:
  - Baud counter width is clog2(CLOCKS_POR_BIT); counts 0..CLOCKS_POR_BIT-1.
  - Every line bit lasts exactly CLOCKS_POR_BIT cycles.
- State machine (bitSerialAtual is registered and changes on the same edge as the state):
  - OCIOSO:
    - Line=1.
    - If the FIFO is not empty: pop into the shift register, clear counters, go to INICIO.
  - INICIO:
    - Line=0 for CLOCKS_POR_BIT cycles, then DADOS.
  - DADOS:
    - Line=data[indice], LSB first; indice runs 0..DATA_BITS-1.
    - After the last bit: go to PARIDADE if PARITY!=0, else PARADA.
  - PARIDADE:
    - Line=XOR of data bits (PARITY=1) or its complement (PARITY=2).
    - Computed from the popped word, not from live input.
  - PARADA:
    - Line=1 for STOP_BITS*CLOCKS_POR_BIT cycles.
    - On the final cycle: bitsEstaoEnviados=1 for exactly one cycle.
    - Then, if the FIFO is not empty: pop and go directly to INICIO (no idle gap). Else go to OCIOSO.
- indicaTransmissao is 1 in INICIO, DADOS, PARIDADE and PARADA; 0 in OCIOSO. It stays 1 across back-to-back frames.
- Latency: a write accepted at edge N into an empty FIFO with the FSM in OCIOSO pops at edge N+1; bitSerialAtual falls at edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLOCKS_POR_BIT cycles.
- Input changes during a frame never affect the frame in flight.

Test Plan:
- 8N1, CLOCKS_POR_BIT=4: write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit. Total 40 cycles. bitsEstaoEnviados is one pulse on cycle 40. indicaTransmissao is high for all 40 cycles.
- PARITY=1 then PARITY=2, write 0xA5 -> parity bit 0 (even) and 1 (odd). Frame is 44 cycles. PARITY=1 with 0x07 -> parity bit 1.
- DATA_BITS=7, STOP_BITS=2, write 0x55 -> 7 data bits 1,0,1,0,1,0,1. Stop high for 8 cycles. Frame is 40 cycles.
- Back-to-back: write 0x11, 0x22, 0x33 on consecutive cycles -> three frames with no idle high between the stop bit and the next start bit. Exactly three completion pulses. filaVazia=1 after the third pop.
- Overflow, FIFO_DEPTH=4: write 6 words on consecutive cycles while line idle -> first word pops immediately, 4 remain queued, 6th write is dropped. erroEstouro=1 and filaCheia=1 observed. The 5 accepted words are transmitted in order.
- Reset mid-frame: assert resetN=0 during DADOS with 2 words queued -> bitSerialAtual=1 immediately (before the next edge), FIFO empty, no bitsEstaoEnviados pulse. A new write after release transmits normally.
